// File: rtl/tow_match_scorer.sv
// Tug-of-war marker tracker with latched boosts,
// game counting and a match-win state.
module tow_match_scorer #(
  parameter int STEPS     = 3,
  parameter int GAMES_WIN = 3,
  parameter int CW        = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               winrnd,
  input  logic               right,
  input  logic               leds_on,
  input  logic               tie,
  input  logic [2*STEPS:0]   boost_in,
  input  logic               new_game,
  output logic [2*STEPS:0]   score,
  output logic               game_won_l,
  output logic               game_won_r,
  output logic [CW-1:0]      games_l,
  output logic [CW-1:0]      games_r,
  output logic               match_over
);

  localparam int W  = 2*STEPS+1;
  localparam int PW = $clog2(STEPS+2)+1;
  localparam int XW = PW+2;

  localparam logic [1:0] S_PLAY  = 2'd0;
  localparam logic [1:0] S_WON   = 2'd1;
  localparam logic [1:0] S_MATCH = 2'd2;

  localparam logic signed [PW-1:0] SMAX  = PW'(STEPS);
  localparam logic signed [PW-1:0] SMIN  = PW'(-STEPS);
  localparam logic signed [PW-1:0] WIN_R = PW'(STEPS+1);
  localparam logic signed [PW-1:0] WIN_L = PW'(-(STEPS+1));
  localparam logic signed [XW-1:0] WRX   = XW'(STEPS+1);
  localparam logic signed [XW-1:0] WLX   = XW'(-(STEPS+1));
  localparam logic [CW-1:0]        GMAX  = CW'(GAMES_WIN);

  logic [1:0]           state_q, state_d;
  logic signed [PW-1:0] pos_q, pos_d;
  logic [W-1:0]         boost_q, boost_d;
  logic [CW-1:0]        games_l_q, games_l_d;
  logic [CW-1:0]        games_r_q, games_r_d;
  logic                 won_l_q, won_l_d;
  logic                 won_r_q, won_r_d;

  logic                 in_rng, on_board, boost_hit, up;
  logic signed [XW-1:0] ext, mag, nxt;

  assign in_rng   = (pos_q >= SMIN) && (pos_q <= SMAX);
  assign on_board = (pos_q >= WIN_L) && (pos_q <= WIN_R);

  always_comb begin
    boost_hit = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (pos_q == $signed(PW'(i - STEPS)))
        boost_hit = boost_q[i];
    end
  end

  // jumps always move one step against the pusher
  assign up  = leds_on ? right : ~right;
  assign ext = {{2{pos_q[PW-1]}}, pos_q};
  assign mag = (boost_hit && leds_on) ? XW'(2) : XW'(1);
  assign nxt = up ? (ext + mag) : (ext - mag);

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    games_l_d = games_l_q;
    games_r_d = games_r_q;
    won_l_d   = 1'b0;
    won_r_d   = 1'b0;
    boost_d   = (pos_q == '0) ? boost_in : boost_q;
    case (state_q)
      S_PLAY: begin
        if (winrnd && !tie) begin
          if (!on_board) begin
            pos_d = '0;
          end else if (nxt >= WRX) begin
            pos_d   = WIN_R;
            won_r_d = 1'b1;
            if (games_r_q < GMAX)
              games_r_d = games_r_q + 1'b1;
            state_d = (games_r_d == GMAX) ? S_MATCH : S_WON;
          end else if (nxt <= WLX) begin
            pos_d   = WIN_L;
            won_l_d = 1'b1;
            if (games_l_q < GMAX)
              games_l_d = games_l_q + 1'b1;
            state_d = (games_l_d == GMAX) ? S_MATCH : S_WON;
          end else begin
            pos_d = nxt[PW-1:0];
          end
        end
      end
      S_WON: begin
        if (new_game) begin
          state_d = S_PLAY;
          pos_d   = '0;
        end
      end
      S_MATCH: begin
        if (new_game) begin
          state_d   = S_PLAY;
          pos_d     = '0;
          games_l_d = '0;
          games_r_d = '0;
        end
      end
      default: begin
        state_d = S_PLAY;
        pos_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_PLAY;
      pos_q     <= '0;
      boost_q   <= '0;
      games_l_q <= '0;
      games_r_q <= '0;
      won_l_q   <= 1'b0;
      won_r_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      boost_q   <= boost_d;
      games_l_q <= games_l_d;
      games_r_q <= games_r_d;
      won_l_q   <= won_l_d;
      won_r_q   <= won_r_d;
    end
  end

  always_comb begin
    score = '0;
    if (in_rng) begin
      for (int i = 0; i < W; i++) begin
        if (pos_q == $signed(PW'(STEPS - i)))
          score[i] = 1'b1;
      end
    end else if (pos_q == WIN_R) begin
      score = W'((1 << STEPS) - 1);
    end else if (pos_q == WIN_L) begin
      score = W'(((1 << STEPS) - 1) << (STEPS + 1));
    end else begin
      for (int i = 0; i < W; i += 2)
        score[i] = 1'b1;
    end
  end

  assign game_won_l = won_l_q;
  assign game_won_r = won_r_q;
  assign games_l    = games_l_q;
  assign games_r    = games_r_q;
  assign match_over = (state_q == S_MATCH);

endmodule

// File: tb/tb_tow_match_scorer.sv
// Directed plus random bench for tow_match_scorer
// against an integer-level game model.
module tb_tow_match_scorer;

  localparam int S  = 3;
  localparam int GW = 2;
  localparam int CW = 3;
  localparam int W  = 2*S+1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         winrnd = 1'b0, right = 1'b0;
  logic         leds_on = 1'b0, tie = 1'b0;
  logic         new_game = 1'b0;
  logic [W-1:0] boost_in = '0;
  logic [W-1:0] score;
  logic         game_won_l, game_won_r, match_over;
  logic [CW-1:0] games_l, games_r;

  tow_match_scorer #(.STEPS(S), .GAMES_WIN(GW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .winrnd(winrnd), .right(right),
    .leds_on(leds_on), .tie(tie), .boost_in(boost_in),
    .new_game(new_game), .score(score),
    .game_won_l(game_won_l), .game_won_r(game_won_r),
    .games_l(games_l), .games_r(games_r), .match_over(match_over)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model: 0 = playing, 1 = game won, 2 = match won
  int m_pos, m_gl, m_gr, m_st, m_boost;
  bit m_pl, m_pr;

  task automatic m_reset();
    m_pos = 0; m_gl = 0; m_gr = 0; m_st = 0;
    m_boost = 0; m_pl = 0; m_pr = 0;
  endtask

  function automatic int m_score();
    int full;
    full = (1 << S) - 1;
    if (m_pos >= -S && m_pos <= S) return 1 << (S - m_pos);
    if (m_pos == S+1) return full;
    return full << (S+1);
  endfunction

  task automatic m_step();
    int d, np, nb;
    nb = (m_pos == 0) ? int'(boost_in) : m_boost;
    m_pl = 0; m_pr = 0;
    if (m_st == 0) begin
      if (winrnd && !tie) begin
        if (leds_on) begin
          d = ((m_boost >> (m_pos + S)) & 1) ? 2 : 1;
          if (!right) d = -d;
        end else begin
          d = right ? -1 : 1;
        end
        np = m_pos + d;
        if (np > S+1) np = S+1;
        if (np < -(S+1)) np = -(S+1);
        m_pos = np;
        if (np == S+1) begin
          m_gr++; m_pr = 1;
          m_st = (m_gr == GW) ? 2 : 1;
        end else if (np == -(S+1)) begin
          m_gl++; m_pl = 1;
          m_st = (m_gl == GW) ? 2 : 1;
        end
      end
    end else if (new_game) begin
      m_pos = 0;
      if (m_st == 2) begin m_gl = 0; m_gr = 0; end
      m_st = 0;
    end
    m_boost = nb;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("score", int'(score), m_score());
    chk("games_l", int'(games_l), m_gl);
    chk("games_r", int'(games_r), m_gr);
    chk("won_l", int'(game_won_l), int'(m_pl));
    chk("won_r", int'(game_won_r), int'(m_pr));
    chk("match_over", int'(match_over), (m_st == 2) ? 1 : 0);
  endtask

  task automatic step(input logic w, r, l, t, ng);
    winrnd = w; right = r; leds_on = l; tie = t; new_game = ng;
    @(posedge clk);
    m_step();
    #1;
    chk_all();
    winrnd = 0; new_game = 0; tie = 0;
  endtask

  initial begin
    m_reset();
    #2;
    chk_all();
    chk("rst_score", int'(score), 'b0001000);
    #10 rst_n = 1'b1;

    // right wins a game with plain pushes
    step(1, 1, 1, 0, 0);
    chk("t1_s1", int'(score), 'b0000100);
    step(1, 1, 1, 0, 0);
    chk("t1_s2", int'(score), 'b0000010);
    step(1, 1, 1, 0, 0);
    chk("t1_s3", int'(score), 'b0000001);
    step(1, 1, 1, 0, 0);
    chk("t1_win", int'(score), 'b0000111);
    chk("t1_pulse", int'(game_won_r), 1);
    step(0, 0, 0, 0, 0);
    chk("t1_pulse_end", int'(game_won_r), 0);
    chk("t1_gr", int'(games_r), 1);

    // pushes ignored while a game is won
    repeat (3) step(1, 1, 1, 0, 0);
    chk("t4_hold", int'(score), 'b0000111);
    step(0, 0, 0, 0, 1);
    chk("t4_new", int'(score), 'b0001000);
    chk("t4_gr", int'(games_r), 1);

    // boost at neutral
    boost_in = 7'b0001000;
    step(0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0);
    chk("t2_boost", int'(score), 'b0000010);
    boost_in = 7'b1111111;
    step(1, 1, 1, 0, 0);
    chk("t2_frozen", int'(score), 'b0000001);
    boost_in = '0;
    repeat (3) step(1, 1, 0, 0, 0);

    // jump moves away from the pusher; tie is void
    step(1, 1, 0, 0, 0);
    chk("t3_jump", int'(score), 'b0010000);
    step(1, 0, 1, 1, 0);
    chk("t3_tie", int'(score), 'b0010000);

    // left takes two games for the match
    repeat (3) step(1, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1);
    repeat (4) step(1, 0, 1, 0, 0);
    chk("t5_match", int'(match_over), 1);
    chk("t5_gl", int'(games_l), 2);
    chk("t5_score", int'(score), 'b1110000);
    step(1, 1, 1, 0, 0);
    step(0, 0, 0, 0, 1);
    chk("t5_clr_l", int'(games_l), 0);
    chk("t5_clr_r", int'(games_r), 0);
    chk("t5_nscore", int'(score), 'b0001000);

    // async reset truncates the win pulse
    repeat (4) step(1, 0, 1, 0, 0);
    chk("t6_pulse", int'(game_won_l), 1);
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    chk_all();
    chk("t6_pulse_cut", int'(game_won_l), 0);
    #1 rst_n = 1'b1;

    // random traffic
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 3) == 0) boost_in = W'($urandom);
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
